// File: rtl/tlp_framer.sv
// Serializes one 20-byte TLP per handshake into STP + payload + END on an 8-bit symbol stream.
// Optional type screening at accept is enabled with `define TLP_FRAMER_TYPE_CHECK_EN.
module tlp_framer #(
  parameter int unsigned IFG = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [159:0] tlp_in,
  input  logic         tlp_valid,
  output logic         tlp_ready,
  output logic [7:0]   data_out,
  output logic         datak,
  output logic         tx_busy,
  output logic [3:0]   TLP_count,
  output logic         type_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_PAYLOAD,
    S_EOF,
    S_GAP
  } state_t;

  localparam logic [7:0] SYM_STP   = 8'hFB;
  localparam logic [7:0] SYM_END   = 8'hFD;
  localparam logic [7:0] SYM_IDLE  = 8'h00;
  localparam logic [4:0] LAST_IDX  = 5'd19;
  localparam logic [3:0] GAP_LOAD  = (IFG == 0) ? 4'd0 : 4'(IFG - 1);

  state_t         r_state;
  logic [159:0]   r_hold;
  logic [4:0]     r_idx;
  logic [3:0]     r_gap_cnt;
  logic [7:0]     r_data;
  logic           r_datak;
  logic           r_busy;
  logic [3:0]     r_count;
  logic           r_type_err;

  logic           w_type_ok;
  logic [4:0]     w_idx_nxt;
  logic [7:0]     w_byte_nxt;

`ifdef TLP_FRAMER_TYPE_CHECK_EN
  always_comb begin
    w_type_ok = 1'b0;
    case (tlp_in[31:24])
      8'h00, 8'h20, 8'h40, 8'h60,
      8'h02, 8'h42, 8'h04, 8'h44,
      8'h05, 8'h45, 8'h0A, 8'h4A: w_type_ok = 1'b1;
      default:                    w_type_ok = 1'b0;
    endcase
  end
`else
  assign w_type_ok = 1'b1;
`endif

  assign w_idx_nxt  = r_idx + 5'd1;
  assign w_byte_nxt = r_hold[{w_idx_nxt, 3'b000} +: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_idx      <= '0;
      r_gap_cnt  <= '0;
      r_data     <= SYM_IDLE;
      r_datak    <= 1'b0;
      r_busy     <= 1'b0;
      r_count    <= '0;
      r_type_err <= 1'b0;
    end else begin
      r_type_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_data  <= SYM_IDLE;
          r_datak <= 1'b0;
          if (tlp_valid) begin
            r_hold <= tlp_in;
            if (w_type_ok) begin
              r_state <= S_SOF;
              r_data  <= SYM_STP;
              r_datak <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_type_err <= 1'b1;
            end
          end
        end
        S_SOF: begin
          r_state <= S_PAYLOAD;
          r_idx   <= '0;
          r_data  <= r_hold[7:0];
          r_datak <= 1'b0;
        end
        S_PAYLOAD: begin
          if (r_idx == LAST_IDX) begin
            r_state <= S_EOF;
            r_data  <= SYM_END;
            r_datak <= 1'b1;
          end else begin
            r_idx  <= w_idx_nxt;
            r_data <= w_byte_nxt;
          end
        end
        S_EOF: begin
          r_count <= r_count + 4'd1;
          r_busy  <= 1'b0;
          r_data  <= SYM_IDLE;
          r_datak <= 1'b0;
          if (IFG == 0) begin
            r_state <= S_IDLE;
          end else begin
            r_state   <= S_GAP;
            r_gap_cnt <= GAP_LOAD;
          end
        end
        S_GAP: begin
          r_data  <= SYM_IDLE;
          r_datak <= 1'b0;
          if (r_gap_cnt == 4'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_data  <= SYM_IDLE;
          r_datak <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tlp_ready = (r_state == S_IDLE);
  assign data_out  = r_data;
  assign datak     = r_datak;
  assign tx_busy   = r_busy;
  assign TLP_count = r_count;
  assign type_err  = r_type_err;

endmodule

// File: tb/tb_tlp_framer.sv
// Directed bench for tlp_framer: a per-cycle expected-output queue is filled at each accept
// and drained one entry per clock, compared against the observed output bundle.
module tb_tlp_framer;
  localparam int unsigned IFG = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [159:0] tlp_in;
  logic         tlp_valid;
  logic         tlp_ready;
  logic [7:0]   data_out;
  logic         datak;
  logic         tx_busy;
  logic [3:0]   TLP_count;
  logic         type_err;

  tlp_framer #(.IFG(IFG)) dut (
    .clk       (clk),
    .reset     (reset),
    .tlp_in    (tlp_in),
    .tlp_valid (tlp_valid),
    .tlp_ready (tlp_ready),
    .data_out  (data_out),
    .datak     (datak),
    .tx_busy   (tx_busy),
    .TLP_count (TLP_count),
    .type_err  (type_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic       busy;
    logic       ready;
    logic [3:0] cnt;
    logic       terr;
  } snap_t;

  snap_t      exp_q[$];
  int         n_pass  = 0;
  int         n_total = 0;
  logic [3:0] cnt_model = 4'd0;

  function automatic snap_t sample();
    snap_t s;
    s.data  = data_out;
    s.k     = datak;
    s.busy  = tx_busy;
    s.ready = tlp_ready;
    s.cnt   = TLP_count;
    s.terr  = type_err;
    return s;
  endfunction

  function automatic snap_t mk(input logic [7:0] d, input logic k, input logic busy,
                               input logic ready, input logic terr);
    snap_t s;
    s.data  = d;
    s.k     = k;
    s.busy  = busy;
    s.ready = ready;
    s.cnt   = cnt_model;
    s.terr  = terr;
    return s;
  endfunction

  function automatic logic [159:0] seq160(input logic [7:0] start);
    logic [159:0] v;
    for (int i = 0; i < 20; i++) v[8*i +: 8] = start + 8'(i);
    return v;
  endfunction

  function automatic logic [159:0] rand160();
    logic [159:0] v;
    for (int i = 0; i < 5; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit legal_type(input logic [7:0] t);
`ifdef TLP_FRAMER_TYPE_CHECK_EN
    case (t)
      8'h00, 8'h20, 8'h40, 8'h60, 8'h02, 8'h42,
      8'h04, 8'h44, 8'h05, 8'h45, 8'h0A, 8'h4A: return 1'b1;
      default: return 1'b0;
    endcase
`else
    return (t === t);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic push_frame(input logic [159:0] d);
    if (!legal_type(d[31:24])) begin
      exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b1));
      exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
      return;
    end
    exp_q.push_back(mk(8'hFB, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 20; i++) exp_q.push_back(mk(d[8*i +: 8], 1'b0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(mk(8'hFD, 1'b1, 1'b1, 1'b0, 1'b0));
    cnt_model = cnt_model + 4'd1;
    for (int i = 0; i < int'(IFG); i++) exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
  endtask

  // First comparison happens in the current cycle; each further entry one clock later.
  task automatic drain(input string tag);
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("%s[%0d]", tag, i), 32'(sample()), 32'(exp_q.pop_front()));
      i++;
    end
  endtask

  // Entered and left #1 after a rising edge, in a cycle where the framer is IDLE.
  task automatic do_frame(input logic [159:0] d, input bit keep_valid, input string tag);
    tlp_in    = d;
    tlp_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_valid) tlp_valid = 1'b0;
    tlp_in = rand160();
    push_frame(d);
    drain(tag);
  endtask

  task automatic apply_reset(input string tag);
    #3;
    reset = 1'b0;
    #1;
    cnt_model = 4'd0;
    check(tag, 32'(sample()), 32'(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0)));
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [159:0] d;
    reset     = 1'b0;
    tlp_valid = 1'b0;
    tlp_in    = '0;
    #2;
    check("reset_state", 32'(sample()), 32'(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0)));
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    drain("idle_no_valid");

    // Abandon a frame with reset in cycle E+10.
    tlp_in    = seq160(8'h40);
    tlp_valid = 1'b1;
    @(posedge clk);
    #1;
    tlp_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("reset_mid_frame", 32'(sample()), 32'(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0)));
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 25; i++) exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    drain("after_abort");

    do_frame(seq160(8'h10), 1'b0, "single");
    check("single_count", 32'(TLP_count), legal_type(8'h13) ? 32'd1 : 32'd0);

    apply_reset("reset_before_b2b");
    for (int f = 0; f < 3; f++) begin
      d = rand160();
      d[31:24] = 8'h40;
      do_frame(d, f < 2, $sformatf("b2b%0d", f));
    end
    check("b2b_count", 32'(TLP_count), 32'd3);

    d = seq160(8'h30);
    d[31:24] = 8'h4A;
    do_frame(d, 1'b0, "type_4a");
    d[31:24] = 8'h7F;
    do_frame(d, 1'b0, "type_7f");

    apply_reset("reset_before_wrap");
    for (int f = 1; f <= 17; f++) begin
      d = rand160();
      d[31:24] = 8'h60;
      do_frame(d, 1'b0, $sformatf("wrap%0d", f));
      if (f == 15) check("count_after_15", 32'(TLP_count), 32'd15);
      if (f == 16) check("count_after_16", 32'(TLP_count), 32'd0);
      if (f == 17) check("count_after_17", 32'(TLP_count), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tlp_framer.md
# tlp_framer

Transmit-side counterpart of the byte-stream TLP detector. Accepts one 160-bit (20-byte) TLP per valid/ready handshake and serializes it onto an 8-bit symbol stream as STP (8'hFB, K) + 20 payload bytes + END (8'hFD, K), followed by idle bytes. Its output can drive the detector's `data_in` directly for loopback. It also keeps a running 4-bit count of transmitted TLPs.

## Interface
- `IFG`, default 1: extra idle bytes after END, range 0..15; minimum idle bytes between END and the next STP is IFG+1.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `tlp_in`  in  160: TLP to send; byte k = `tlp_in[8k+7:8k]`; byte 0 is sent first; byte 3 (`[31:24]`) is the type byte.
- `tlp_valid`  in  1: `tlp_in` is valid.
- `tlp_ready`  out  1: block can accept a TLP; high only in IDLE.
- `data_out`  out  8: registered symbol stream.
- `datak`  out  1: high when `data_out` is a control symbol (STP/END).
- `tx_busy`  out  1: high on every cycle from STP through END inclusive.
- `TLP_count`  out  4: number of TLPs fully sent; wraps modulo 16.
- `type_err`  out  1: one-cycle pulse on a rejected type; tied 0 without the macro.

## Operation
- States: IDLE, SOF, PAYLOAD, EOF, GAP.
- Byte index counter: 5 bits, 0..19, used in PAYLOAD.
- Accept rule: a TLP is accepted on a rising edge where state==IDLE and `tlp_valid`=1. `tlp_in` is latched into a 160-bit holding register. The source may change `tlp_in` the cycle after acceptance.
- State transitions:
  - IDLE→SOF on accept.
  - SOF→PAYLOAD after 1 cycle.
  - PAYLOAD→EOF after the index reaches 19.
  - EOF→GAP.
  - GAP→IDLE after IFG cycles. With IFG=0, EOF goes straight to IDLE.
- Per-state output (registered, valid the cycle the state is active):
  - IDLE and GAP: `data_out`=8'h00, `datak`=0.
  - SOF: 8'hFB, `datak`=1.
  - PAYLOAD: byte[index], `datak`=0.
  - EOF: 8'hFD, `datak`=1.
- `TLP_count` increments by 1 on the edge leaving EOF; 15→0 wrap.
- `tlp_ready` = (state==IDLE), decoded combinationally from the state register.
- Reset values: state IDLE, `data_out`=8'h00, `datak`=0, `tx_busy`=0, `TLP_count`=0, `type_err`=0, holding register 0. `tlp_ready`=1 while and after reset.
- Reset mid-frame: the frame is abandoned immediately, no END is emitted, and `TLP_count` is not incremented.
- `tlp_valid` low in IDLE: stream stays 8'h00 indefinitely.

## Timing
- Accept at edge E gives:
  - STP during cycle E+1.
  - Payload bytes 0..19 during E+2..E+21.
  - END during E+22.
  - Idle during E+23..E+22+IFG.
  - IDLE (`tlp_ready`=1) at E+23+IFG.
- Frame length is 22 symbols. Back-to-back throughput is one TLP per 23+IFG cycles, with IFG+1 idle bytes between frames.
- `tlp_ready` drops in the cycle after acceptance and stays low until IDLE.
- `TLP_count` shows the new value during cycle E+23.

## Configuration
- Macro: `TLP_FRAMER_TYPE_CHECK_EN`.
- Defined: at accept, byte 3 of `tlp_in` is checked against the legal set 8'h00/8'h20 (MRd), 8'h40/8'h60 (MWr), 8'h02 (IORd), 8'h42 (IOWr), 8'h04 (CfgRd0), 8'h44 (CfgWr0), 8'h05 (CfgRd1), 8'h45 (CfgWr1), 8'h0A (Cpl), 8'h4A (CplD).
  - On an illegal type, the handshake still completes but nothing is transmitted and the state stays IDLE.
  - `type_err`=1 during cycle E+1 only.
  - `TLP_count` is unchanged.
- Undefined: every TLP is sent unchecked; `type_err` is constant 0.

## Test plan
- Single frame, IFG=1: `tlp_in` bytes 0..19 = 8'h10..8'h23 (byte 3 = 8'h13 with macro off), accepted at E -> E+1 FB/K, E+2..E+21 8'h10..8'h23/non-K, E+22 FD/K, E+23..E+24 00, `TLP_count`=1, `tlp_ready` high at E+24.
- `tlp_valid` held high for 3 TLPs -> exactly 2 idle bytes between each END and the next STP; `TLP_count`=3.
- Reset asserted at E+10 -> `data_out`=00, `datak`=0, `tx_busy`=0 immediately; no FD appears; `TLP_count` keeps its pre-frame value; the next frame after release is correct.
- 17 frames -> `TLP_count` reads 15 after frame 15, 0 after frame 16, 1 after frame 17.
- Macro on: byte 3 = 8'h4A -> full frame sent; byte 3 = 8'h7F -> `type_err` pulse at E+1, no FB emitted, `tlp_ready` high at E+1, count unchanged.
- Loopback into the detector: MWr frame with byte 3 = 8'h40 -> detector increments its count and flags MWr.
